// File: rtl/bram_rd_arbiter.sv
// Round-robin arbiter sharing one BRAM read port between two requesters, with a
// write pass-through, same-address read-after-write stall and per-requester response slots.
module bram_rd_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH_RAM = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic [ADDR_WIDTH_RAM-1:0] req0_addr,
    output logic                      req0_ready,
    output logic                      rsp0_valid,
    output logic [DATA_WIDTH-1:0]     rsp0_data,
    input  logic                      rsp0_ready,
    input  logic                      req1_valid,
    input  logic [ADDR_WIDTH_RAM-1:0] req1_addr,
    output logic                      req1_ready,
    output logic                      rsp1_valid,
    output logic [DATA_WIDTH-1:0]     rsp1_data,
    input  logic                      rsp1_ready,
    input  logic                      wr_valid,
    input  logic [ADDR_WIDTH_RAM-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      ram_wen,
    output logic [ADDR_WIDTH_RAM-1:0] ram_addrW,
    output logic [DATA_WIDTH-1:0]     ram_din,
    output logic                      ram_en,
    output logic [ADDR_WIDTH_RAM-1:0] ram_addrR,
    input  logic [DATA_WIDTH-1:0]     ram_dout
);

    logic pend0, pend1;
    logic sel_d;
    logic last_grant;
    logic elig0, elig1;
    logic grant0, grant1;
    logic cap0, cap1;

    // The BRAM returns stale data on a same-address read/write, so such a read waits a cycle.
    always_comb begin
        elig0  = req0_valid && !pend0 && (!rsp0_valid || rsp0_ready)
                 && !(wr_valid && (wr_addr == req0_addr));
        elig1  = req1_valid && !pend1 && (!rsp1_valid || rsp1_ready)
                 && !(wr_valid && (wr_addr == req1_addr));
        grant0 = rst_n && elig0 && (!elig1 || last_grant);
        grant1 = rst_n && elig1 && (!elig0 || !last_grant);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign ram_en     = grant0 | grant1;
    assign ram_addrR  = grant0 ? req0_addr : (grant1 ? req1_addr : '0);

    assign ram_wen    = wr_valid & rst_n;
    assign ram_addrW  = wr_addr;
    assign ram_din    = wr_data;

    assign cap0 = pend0 & ~sel_d;
    assign cap1 = pend1 & sel_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend0      <= 1'b0;
            pend1      <= 1'b0;
            sel_d      <= 1'b0;
            last_grant <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            // A read is in flight for exactly one cycle; a requester cannot be re-granted meanwhile.
            pend0 <= grant0;
            pend1 <= grant1;
            if (grant0 || grant1) begin
                last_grant <= grant1;
                sel_d      <= grant1;
            end
            if (cap0) begin
                rsp0_valid <= 1'b1;
                rsp0_data  <= ram_dout;
            end else if (rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (cap1) begin
                rsp1_valid <= 1'b1;
                rsp1_data  <= ram_dout;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Bench for bram_rd_arbiter: BRAM model, per-cycle reference model of the arbitration
// rules, single-cycle vector table, multi-cycle corner sequences and randomized traffic.
module tb_bram_rd_arbiter;

    localparam int DW = 32;
    localparam int AW = 7;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [AW-1:0] req0_addr, req1_addr, wr_addr, ram_addrW, ram_addrR;
    logic [DW-1:0] rsp0_data, rsp1_data, wr_data, ram_din, ram_dout;
    logic          wr_valid, ram_wen, ram_en;

    bram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH_RAM(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_wen(ram_wen), .ram_addrW(ram_addrW), .ram_din(ram_din),
        .ram_en(ram_en), .ram_addrR(ram_addrR), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port BRAM: registered read, old data on a same-address collision.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_wen) bram[ram_addrW] <= ram_din;
        if (ram_en)  ram_dout <= bram[ram_addrR];
    end

    int n_vec;
    int n_err;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp_v);
        end
    endfunction

    // Stimulus for the next cycle.
    logic          d_rst, d_r0v, d_r1v, d_s0r, d_s1r, d_wv;
    logic [AW-1:0] d_r0a, d_r1a, d_wa;
    logic [DW-1:0] d_wd;

    // Reference model: shadow memory, response slots, list of reads in flight.
    typedef struct {
        int            who;
        logic [DW-1:0] data;
        int            due;
    } fly_t;

    fly_t          flyq[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit            m_rv [2];
    logic [DW-1:0] m_rd [2];
    int            m_last;
    int            cyc;

    function automatic bit in_flight(input int n);
        foreach (flyq[i]) if (flyq[i].who == n) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        d_rst = 1'b1; d_r0v = 1'b0; d_r1v = 1'b0; d_wv = 1'b0;
        d_s0r = 1'b1; d_s1r = 1'b1;
        d_r0a = '0; d_r1a = '0; d_wa = '0; d_wd = '0;
    endtask

    task automatic tick();
        bit e0, e1;
        int g;
        logic [AW-1:0] exp_ar;
        @(negedge clk);
        rst_n = d_rst;
        req0_valid = d_r0v; req0_addr = d_r0a; rsp0_ready = d_s0r;
        req1_valid = d_r1v; req1_addr = d_r1a; rsp1_ready = d_s1r;
        wr_valid = d_wv; wr_addr = d_wa; wr_data = d_wd;
        #2;
        e0 = d_rst && d_r0v && !in_flight(0) && (!m_rv[0] || d_s0r) && !(d_wv && d_wa == d_r0a);
        e1 = d_rst && d_r1v && !in_flight(1) && (!m_rv[1] || d_s1r) && !(d_wv && d_wa == d_r1a);
        g = -1;
        if (e0 && e1)  g = (m_last == 0) ? 1 : 0;
        else if (e0)   g = 0;
        else if (e1)   g = 1;
        exp_ar = (g == 0) ? d_r0a : ((g == 1) ? d_r1a : '0);
        chk("m_req0_ready", int'(req0_ready), int'(g == 0));
        chk("m_req1_ready", int'(req1_ready), int'(g == 1));
        chk("m_ram_en",     int'(ram_en),     int'(g >= 0));
        chk("m_ram_addrR",  int'(ram_addrR),  int'(exp_ar));
        chk("m_ram_wen",    int'(ram_wen),    int'(d_wv && d_rst));
        chk("m_ram_addrW",  int'(ram_addrW),  int'(d_wa));
        chk("m_ram_din",    int'(ram_din),    int'(d_wd));
        chk("m_rsp0_valid", int'(rsp0_valid), int'(d_rst && m_rv[0]));
        chk("m_rsp1_valid", int'(rsp1_valid), int'(d_rst && m_rv[1]));
        chk("m_rsp0_data",  int'(rsp0_data),  d_rst ? int'(m_rd[0]) : 0);
        chk("m_rsp1_data",  int'(rsp1_data),  d_rst ? int'(m_rd[1]) : 0);
        // Advance the model across the coming clock edge.
        if (!d_rst) begin
            flyq.delete();
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            m_rd[0] = '0;   m_rd[1] = '0;
            m_last = 1;
        end else begin
            if (m_rv[0] && d_s0r) m_rv[0] = 1'b0;
            if (m_rv[1] && d_s1r) m_rv[1] = 1'b0;
            for (int i = flyq.size() - 1; i >= 0; i--) begin
                if (flyq[i].due == cyc + 1) begin
                    m_rv[flyq[i].who] = 1'b1;
                    m_rd[flyq[i].who] = flyq[i].data;
                    flyq.delete(i);
                end
            end
            if (g >= 0) begin
                flyq.push_back('{who: g, data: ref_mem[exp_ar], due: cyc + 2});
                m_last = g;
            end
            if (d_wv) ref_mem[d_wa] = d_wd;
        end
        cyc++;
    endtask

    typedef struct {
        logic          r0v;
        logic [AW-1:0] r0a;
        logic          r1v;
        logic [AW-1:0] r1a;
        logic          wv;
        logic [AW-1:0] wa;
        logic          rdy0;
        logic          rdy1;
        logic          en;
        logic [AW-1:0] ar;
    } vec_t;

    vec_t tbl [10];
    int   cnt;

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; m_last = 1;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = '0; m_rd[1] = '0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; rsp1_ready = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;

        tbl[0] = '{1'b0, 7'd0,  1'b0, 7'd0,   1'b0, 7'd0,  1'b0, 1'b0, 1'b0, 7'd0};
        tbl[1] = '{1'b1, 7'd5,  1'b0, 7'd0,   1'b0, 7'd0,  1'b1, 1'b0, 1'b1, 7'd5};
        tbl[2] = '{1'b0, 7'd0,  1'b1, 7'd9,   1'b0, 7'd0,  1'b0, 1'b1, 1'b1, 7'd9};
        tbl[3] = '{1'b1, 7'd5,  1'b1, 7'd9,   1'b0, 7'd0,  1'b1, 1'b0, 1'b1, 7'd5};
        tbl[4] = '{1'b1, 7'd5,  1'b0, 7'd0,   1'b1, 7'd5,  1'b0, 1'b0, 1'b0, 7'd0};
        tbl[5] = '{1'b1, 7'd5,  1'b0, 7'd0,   1'b1, 7'd6,  1'b1, 1'b0, 1'b1, 7'd5};
        tbl[6] = '{1'b1, 7'd5,  1'b1, 7'd9,   1'b1, 7'd5,  1'b0, 1'b1, 1'b1, 7'd9};
        tbl[7] = '{1'b1, 7'd5,  1'b1, 7'd9,   1'b1, 7'd9,  1'b1, 1'b0, 1'b1, 7'd5};
        tbl[8] = '{1'b1, 7'd12, 1'b1, 7'd12,  1'b1, 7'd12, 1'b0, 1'b0, 1'b0, 7'd0};
        tbl[9] = '{1'b0, 7'd0,  1'b1, 7'd127, 1'b1, 7'd0,  1'b0, 1'b1, 1'b1, 7'd127};

        // Reset state, with requests and a write presented while in reset.
        idle(); d_rst = 1'b0; d_r0v = 1'b1; d_r1v = 1'b1; d_wv = 1'b1;
        tick();
        chk("rst_ram_en", int'(ram_en), 0);
        chk("rst_ram_wen", int'(ram_wen), 0);
        chk("rst_rsp0_valid", int'(rsp0_valid), 0);
        chk("rst_rsp1_data", int'(rsp1_data), 0);
        idle(); d_rst = 1'b0;
        tick();

        // Preload every BRAM word through the write path.
        idle();
        for (int i = 0; i < (1 << AW); i++) begin
            d_wv = 1'b1; d_wa = AW'(i);
            d_wd = (i == 5) ? 32'h0000_00A5 : ((i == 9) ? 32'h0000_003C : $urandom);
            tick();
        end
        idle();

        // Single read with latency 2 and a one-cycle response.
        d_r0v = 1'b1; d_r0a = 7'd5;
        tick(); chk("A_accept", int'(req0_ready), 1);
        d_r0v = 1'b0;
        tick(); chk("A_t1_valid", int'(rsp0_valid), 0);
        tick(); chk("A_t2_valid", int'(rsp0_valid), 1);
        chk("A_t2_data", int'(rsp0_data), 32'h0000_00A5);
        tick(); chk("A_t3_valid", int'(rsp0_valid), 0);

        // Both requesters streaming: grants alternate starting with requester 0.
        idle(); d_rst = 1'b0; tick();
        idle(); d_r0v = 1'b1; d_r0a = 7'd5; d_r1v = 1'b1; d_r1a = 7'd9;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("B_rdy0", int'(req0_ready), int'(i % 2 == 0));
            chk("B_rdy1", int'(req1_ready), int'(i % 2 == 1));
            chk("B_en", int'(ram_en), 1);
            chk("B_v0", int'(rsp0_valid), int'(i >= 2 && i % 2 == 0));
            chk("B_v1", int'(rsp1_valid), int'(i >= 3 && i % 2 == 1));
            if (i >= 2 && i % 2 == 0) chk("B_d0", int'(rsp0_data), 32'h0000_00A5);
            if (i >= 3 && i % 2 == 1) chk("B_d1", int'(rsp1_data), 32'h0000_003C);
        end
        idle(); tick(); tick();

        // Same-address write blocks the read for one cycle; the read sees new data.
        d_r0v = 1'b1; d_r0a = 7'd5; d_wv = 1'b1; d_wa = 7'd5; d_wd = 32'h0000_0077;
        tick(); chk("C_blocked", int'(req0_ready), 0);
        d_wv = 1'b0;
        tick(); chk("C_accept", int'(req0_ready), 1);
        d_r0v = 1'b0;
        tick();
        tick(); chk("C_valid", int'(rsp0_valid), 1);
        chk("C_data", int'(rsp0_data), 32'h0000_0077);
        tick();

        // Requester 0 stalls its response slot; requester 1 keeps being served.
        d_r0v = 1'b1; d_r0a = 7'd5; d_r1v = 1'b1; d_r1a = 7'd9; d_s0r = 1'b0; d_s1r = 1'b1;
        tick(); tick(); tick();
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("D_hold_valid", int'(rsp0_valid), 1);
            chk("D_hold_data", int'(rsp0_data), 32'h0000_0077);
            chk("D_no_regrant", int'(req0_ready), 0);
            if (req1_ready) cnt++;
        end
        chk("D_req1_served", cnt, 2);

        // Handshake and new grant on the same edge: valid drops for one cycle only.
        d_s0r = 1'b1; d_r0a = 7'd9;
        tick(); chk("E_grant", int'(req0_ready), 1);
        chk("E_valid_hs", int'(rsp0_valid), 1);
        tick(); chk("E_gap", int'(rsp0_valid), 0);
        tick(); chk("E_back", int'(rsp0_valid), 1);
        chk("E_new_data", int'(rsp0_data), 32'h0000_003C);
        idle(); tick(); tick(); tick();

        // Reset one cycle after a grant drops the read; first tie after reset goes to 0.
        d_r0v = 1'b1; d_r0a = 7'd5;
        tick(); chk("F_grant", int'(req0_ready), 1);
        d_rst = 1'b0; d_r1v = 1'b1; d_r1a = 7'd9; d_wv = 1'b1; d_wa = 7'd20;
        tick();
        chk("F_rst_en", int'(ram_en), 0);
        chk("F_rst_wen", int'(ram_wen), 0);
        chk("F_rst_rdy0", int'(req0_ready), 0);
        chk("F_rst_v0", int'(rsp0_valid), 0);
        d_wv = 1'b0;
        tick(); chk("F_rst_en2", int'(ram_en), 0);
        d_rst = 1'b1;
        tick();
        chk("F_tie_rdy0", int'(req0_ready), 1);
        chk("F_tie_rdy1", int'(req1_ready), 0);
        chk("F_v0_rel", int'(rsp0_valid), 0);
        tick();
        chk("F_v0_next", int'(rsp0_valid), 0);
        chk("F_v1_next", int'(rsp1_valid), 0);

        // Single-cycle arbitration vectors, each from a fresh reset.
        foreach (tbl[i]) begin
            idle(); d_rst = 1'b0; tick();
            idle();
            d_r0v = tbl[i].r0v; d_r0a = tbl[i].r0a;
            d_r1v = tbl[i].r1v; d_r1a = tbl[i].r1a;
            d_wv  = tbl[i].wv;  d_wa  = tbl[i].wa;
            d_wd  = 32'h1234_0000 | 32'(i);
            tick();
            chk("T_rdy0", int'(req0_ready), int'(tbl[i].rdy0));
            chk("T_rdy1", int'(req1_ready), int'(tbl[i].rdy1));
            chk("T_en", int'(ram_en), int'(tbl[i].en));
            chk("T_addrR", int'(ram_addrR), int'(tbl[i].ar));
        end

        // Randomized traffic on a narrow address range to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            d_rst = ($urandom_range(0, 199) != 0);
            d_r0v = ($urandom_range(0, 9) < 7);
            d_r1v = ($urandom_range(0, 9) < 7);
            d_r0a = AW'($urandom_range(0, 7));
            d_r1a = AW'($urandom_range(0, 7));
            d_s0r = ($urandom_range(0, 9) < 6);
            d_s1r = ($urandom_range(0, 9) < 6);
            d_wv  = ($urandom_range(0, 1) == 1);
            d_wa  = AW'($urandom_range(0, 7));
            d_wd  = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_rd_arbiter.md
Name: bram_rd_arbiter

Overview:
- Round-robin arbiter that shares the single read port of the team's dual-port BRAM (1 write port, 1 read port, 1-cycle registered read with read enable) between two read requesters.
- Passes one write stream straight through to the write port.
- Blocks any read to the address being written in the same cycle, so reads always return coherent data.
- Each requester gets a registered response slot with a valid/ready handshake.
- Sits between the BRAM instance and two consumers, e.g. two classifier compute lanes.

Parameters:
- DATA_WIDTH, 32, BRAM word width.
- ADDR_WIDTH_RAM, 7, BRAM address width (depth 2^ADDR_WIDTH_RAM).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 read request.
- req0_addr  in  ADDR_WIDTH_RAM  requester 0 read address.
- req0_ready  out  1  requester 0 request accepted this cycle.
- rsp0_valid  out  1  requester 0 read data available.
- rsp0_data  out  DATA_WIDTH  requester 0 read data.
- rsp0_ready  in  1  requester 0 consumes response.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data, rsp1_ready: same as requester 0, for requester 1.
- wr_valid  in  1  write strobe; always accepted, no backpressure.
- wr_addr  in  ADDR_WIDTH_RAM  write address.
- wr_data  in  DATA_WIDTH  write data.
- ram_wen  out  1  to BRAM wen.
- ram_addrW  out  ADDR_WIDTH_RAM  to BRAM addrW.
- ram_din  out  DATA_WIDTH  to BRAM din.
- ram_en  out  1  to BRAM read enable.
- ram_addrR  out  ADDR_WIDTH_RAM  to BRAM addrR.
- ram_dout  in  DATA_WIDTH  from BRAM dout, valid the cycle after ram_en.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pend0, pend1, rsp0_valid, rsp1_valid and sel_d clear to 0; rsp0_data and rsp1_data clear to 0.
  - last_grant resets to 1, so requester 0 wins first.
  - ram_en, ram_wen, req0_ready and req1_ready are forced 0 while rst_n is low.
- Write path is combinational: ram_wen = wr_valid; ram_addrW = wr_addr; ram_din = wr_data.
- Eligibility for requester N (all conditions required):
  - reqN_valid = 1;
  - pendN = 0;
  - (rspN_valid = 0 or rspN_ready = 1);
  - not (wr_valid = 1 and wr_addr = reqN_addr). This is the RAW block: the BRAM reads old data on a same-address collision, so the request stalls instead.
- Arbitration is combinational, one grant per cycle:
  - If only one requester is eligible, it is granted.
  - If both are eligible, the one that is not last_grant is granted.
  - reqN_ready = grantN; ram_en = grant0 | grant1; ram_addrR = address of the granted requester, else 0.
  - On a grant, last_grant <= granted index, pendN <= 1, sel_d <= N.
- Pipeline for a request accepted in cycle T:
  - T: ram_en high.
  - T+1: ram_dout valid; at the T+1 edge rspN_data <= ram_dout, rspN_valid <= 1, pendN <= 0.
  - rspN_valid is therefore first visible in T+2. Accept-to-response latency is 2 cycles.
- Response handshake:
  - rspN_valid and rspN_data hold stable until rspN_valid & rspN_ready.
  - On that handshake rspN_valid clears, unless a capture for N happens on the same edge, in which case it stays 1 with the new data.
- Throughput:
  - Each requester has at most 1 outstanding read, so a single requester gets 1 read per 2 cycles.
  - Two requesters interleave to 1 read per cycle on the port.
- Simultaneous events:
  - A write and a read to different addresses proceed in the same cycle.
  - A write to an address held in a response slot does not alter the captured data.
- A request that is not accepted must be held by the requester; the arbiter holds no request state.
- Reset asserted mid-operation drops in-flight reads and pending responses; no response is issued after reset.

Test Plan:
- Preload RAM[5]=0xA5, RAM[9]=0x3C. req0 addr 5 accepted at T, rsp0_ready=1 → rsp0_valid at T+2 with 0x0000_00A5, single cycle.
- Both requesters valid continuously, addr 5 and 9, both rsp_ready=1 → grants alternate 0,1,0,1 starting with 0; ram_en high every cycle after the first; each port receives a response every 2 cycles.
- wr_valid addr 5 data 0x77 in the same cycle req0 addr 5 → req0_ready=0 that cycle; accepted next cycle; rsp0_data=0x77.
- rsp0_ready=0 for 4 cycles with rsp0_valid=1 → req0 is not re-granted and rsp0_data stays stable; req1 is still served every 2 cycles.
- Back-to-back handshake: rsp0_ready=1 while req0 is granted in the same cycle → rsp0_valid drops for exactly 1 cycle, then rises with the new data.
- Assert rst_n=0 one cycle after a grant → rsp valids stay 0 after release, ram_en=0 during reset, and the first post-reset tie is granted to requester 0.
